// File: rtl/spi_master.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_master: transmit-only SPI master, SCLK idle low, MSB first           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module spi_master #(
  parameter int DATA_WIDTH  = 16,
  parameter int HALF_PERIOD = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  DIN,
  output logic                  SCLK,
  output logic                  busy
);

  localparam int PH_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int BC_W = $clog2(DATA_WIDTH);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF_PERIOD - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [PH_W-1:0]         phase_q, phase_d;
  logic [BC_W-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic                    sclk_q, sclk_d;
  logic                    din_q, din_d;
  logic                    busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    sclk_d    = sclk_q;
    din_d     = din_q;
    busy_d    = busy_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          shreg_d   = data_in;
          din_d     = data_in[DATA_WIDTH-1];
          busy_d    = 1'b1;
          sclk_d    = 1'b0;
          bit_cnt_d = '0;
          phase_d   = '0;
          state_d   = S_LOW;
        end
      end
      S_LOW: begin
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          sclk_d  = 1'b1;
          state_d = S_HIGH;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          sclk_d  = 1'b0;
          if (bit_cnt_q == BC_LAST) begin
            // Last bit done: SCLK and busy drop together so the host can release CS.
            din_d   = 1'b0;
            busy_d  = 1'b0;
            shreg_d = '0;
            state_d = S_IDLE;
          end else begin
            shreg_d   = {shreg_q[DATA_WIDTH-2:0], 1'b0};
            din_d     = shreg_q[DATA_WIDTH-2];
            bit_cnt_d = bit_cnt_q + 1'b1;
            state_d   = S_LOW;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        sclk_d  = 1'b0;
        din_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      sclk_q    <= 1'b0;
      din_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      sclk_q    <= sclk_d;
      din_q     <= din_d;
      busy_q    <= busy_d;
    end
  end

  assign DIN  = din_q;
  assign SCLK = sclk_q;
  assign busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_spi_master: self-checking bench for spi_master (three configurations) |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_spi_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  start_v;
  logic [15:0] data_v [3];
  wire  [2:0]  sclk_w;
  wire  [2:0]  din_w;
  wire  [2:0]  busy_w;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  spi_master #(.DATA_WIDTH(16), .HALF_PERIOD(1)) u_dflt (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .data_in(data_v[0]),
    .DIN(din_w[0]), .SCLK(sclk_w[0]), .busy(busy_w[0]));

  spi_master #(.DATA_WIDTH(16), .HALF_PERIOD(3)) u_hp3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .data_in(data_v[1]),
    .DIN(din_w[1]), .SCLK(sclk_w[1]), .busy(busy_w[1]));

  spi_master #(.DATA_WIDTH(8), .HALF_PERIOD(1)) u_dw8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .data_in(data_v[2][7:0]),
    .DIN(din_w[2]), .SCLK(sclk_w[2]), .busy(busy_w[2]));

  typedef struct {
    logic [15:0] word;
    logic [15:0] exp_rx;
    int          exp_busy;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: cycle k after the start edge has SCLK = (k/hp) odd, and
  // carries bit dw-1-k/(2*hp) of the word; the receiver shifts DIN on each SCLK rise.
  task automatic run_xfer(input int sel, input int hp, input int dw,
                          input logic [15:0] word, input logic [15:0] exp_rx,
                          input int exp_busy, input int repulse_at, input bit hold,
                          input string tag);
    int          n        = 2 * hp * dw;
    int          busy_cnt = 0;
    int          edges    = 0;
    logic [15:0] rx       = '0;
    logic        prev     = 1'b0;
    data_v[sel]  = word;
    start_v[sel] = 1'b1;
    step();
    if (!hold) start_v[sel] = 1'b0;
    for (int k = 0; k < n + 8; k++) begin
      if (busy_w[sel] !== 1'b1) break;
      busy_cnt++;
      if (k < n) begin
        check($sformatf("%s sclk k=%0d", tag, k), 32'(sclk_w[sel]), 32'((k / hp) % 2));
        check($sformatf("%s din k=%0d", tag, k), 32'(din_w[sel]), 32'(word[dw - 1 - k / (2 * hp)]));
      end
      if (sclk_w[sel] && !prev) begin
        rx = {rx[14:0], din_w[sel]};
        edges++;
      end
      prev = sclk_w[sel];
      if (repulse_at >= 0 && k == repulse_at) begin
        start_v[sel] = 1'b1;
        data_v[sel]  = 16'hAAAA;
      end else if (repulse_at >= 0 && k == repulse_at + 1) begin
        start_v[sel] = 1'b0;
        data_v[sel]  = 16'($urandom);
      end else begin
        data_v[sel]  = 16'($urandom);
      end
      step();
    end
    check({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_busy));
    check({tag, " busy low at end"}, 32'(busy_w[sel]), 32'd0);
    check({tag, " sclk edges"}, 32'(edges), 32'(dw));
    check({tag, " rx word"}, 32'(rx), 32'(exp_rx));
    check({tag, " sclk at fall"}, 32'(sclk_w[sel]), 32'd0);
    check({tag, " din at fall"}, 32'(din_w[sel]), 32'd0);
  endtask

  task automatic wait_idle(input int sel, input string tag);
    for (int i = 0; i < 300 && busy_w[sel] !== 1'b0; i++) step();
    check({tag, " idle reached"}, 32'(busy_w[sel]), 32'd0);
  endtask

  initial begin
    logic [15:0] w;
    rst_n   = 1'b1;
    start_v = '0;
    for (int i = 0; i < 3; i++) data_v[i] = '0;
    #2 rst_n = 1'b0;
    #10;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset sclk[%0d]", i), 32'(sclk_w[i]), 32'd0);
      check($sformatf("reset din[%0d]", i),  32'(din_w[i]),  32'd0);
      check($sformatf("reset busy[%0d]", i), 32'(busy_w[i]), 32'd0);
    end
    step();
    rst_n = 1'b1;

    tbl[0] = '{16'h0C01, 16'h0C01, 32};
    tbl[1] = '{16'hFFFF, 16'hFFFF, 32};
    tbl[2] = '{16'h0000, 16'h0000, 32};
    tbl[3] = '{16'h8000, 16'h8000, 32};
    tbl[4] = '{16'h0001, 16'h0001, 32};
    for (int i = 5; i < 8; i++) begin
      w = 16'($urandom);
      tbl[i] = '{w, w, 32};
    end
    for (int i = 0; i < 8; i++)
      run_xfer(0, 1, 16, tbl[i].word, tbl[i].exp_rx, tbl[i].exp_busy, -1, 1'b0,
               $sformatf("tbl%0d", i));

    // Re-pulsed start with new data mid-transfer must be ignored entirely.
    run_xfer(0, 1, 16, 16'h5C3A, 16'h5C3A, 32, 10, 1'b0, "repulse");
    for (int i = 0; i < 4; i++) begin
      check($sformatf("no queued xfer c%0d", i), 32'(busy_w[0]), 32'd0);
      step();
    end

    // Asynchronous reset in the middle of a transfer.
    data_v[0]  = 16'h0C01;
    start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    repeat (14) step();
    rst_n = 1'b0;
    #1;
    check("midreset sclk", 32'(sclk_w[0]), 32'd0);
    check("midreset din",  32'(din_w[0]),  32'd0);
    check("midreset busy", 32'(busy_w[0]), 32'd0);
    #1 rst_n = 1'b1;
    run_xfer(0, 1, 16, 16'h9AB3, 16'h9AB3, 32, -1, 1'b0, "post-reset");

    // Held start: one idle cycle, then the next transfer begins.
    run_xfer(0, 1, 16, 16'h3C5A, 16'h3C5A, 32, -1, 1'b1, "held");
    step();
    check("held restart busy", 32'(busy_w[0]), 32'd1);
    start_v[0] = 1'b0;
    wait_idle(0, "held");

    run_xfer(1, 3, 16, 16'h0F00, 16'h0F00, 96, -1, 1'b0, "hp3 0F00");
    w = 16'($urandom);
    run_xfer(1, 3, 16, w, w, 96, -1, 1'b0, "hp3 rand");

    run_xfer(2, 1, 8, 16'h00A5, 16'h00A5, 16, -1, 1'b0, "dw8 A5");
    w = 16'($urandom_range(0, 255));
    run_xfer(2, 1, 8, w, w, 16, -1, 1'b0, "dw8 rand");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, meaning the number of bits per transfer (minimum 2).
REQ-002 The block SHALL have parameter HALF_PERIOD, default 1, meaning the number of clk cycles per SCLK phase (low or high); the minimum is 1.
REQ-003 The block SHALL have a port clk, input, 1 bit: the single clock; all logic SHALL run on its rising edge.
REQ-004 The block SHALL have a port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have a port start, input, 1 bit: a transfer request, sampled on the rising edge of clk.
REQ-006 The block SHALL have a port data_in, input, DATA_WIDTH bits: the word to transmit, MSB first.
REQ-007 The block SHALL have a port DIN, output, 1 bit: serial data, launched while SCLK is low.
REQ-008 The block SHALL have a port SCLK, output, 1 bit: serial clock, idle low; the receiver samples DIN on the SCLK rising edge.
REQ-009 The block SHALL have a port busy, output, 1 bit: high while a transfer is in progress.
REQ-010 All outputs SHALL be registered; the block SHALL have no chip-select output, because the host owns chip select.

Function
REQ-011 The state machine SHALL have the states IDLE, LOW (SCLK=0 phase), HIGH (SCLK=1 phase) and DONE-less return to IDLE.
REQ-012 In IDLE, SCLK SHALL be 0, DIN SHALL be 0 and busy SHALL be 0.
REQ-013 In IDLE, when start=1 at a clk edge, that same edge SHALL do all of the following:
- capture data_in into the shift register;
- set busy=1;
- set DIN=data_in[DATA_WIDTH-1];
- keep SCLK=0;
- set bit_count=0;
- enter LOW.
REQ-014 busy SHALL be high in the cycle immediately following the start edge, with zero latency.
REQ-015 LOW SHALL last HALF_PERIOD cycles, after which the block SHALL set SCLK=1 and enter HIGH; DIN SHALL be held stable.
REQ-016 HIGH SHALL last HALF_PERIOD cycles and then act as follows:
- If bit_count is less than DATA_WIDTH-1: set SCLK=0, shift so that DIN takes the next lower bit, increment bit_count, and enter LOW.
- If bit_count equals DATA_WIDTH-1: set SCLK=0, DIN=0 and busy=0, and enter IDLE.
REQ-017 Each transfer SHALL produce exactly DATA_WIDTH SCLK rising edges, with bits sent MSB to LSB.
REQ-018 busy SHALL stay high for exactly 2*HALF_PERIOD*DATA_WIDTH cycles (32 cycles at the defaults).
REQ-019 When busy falls, SCLK SHALL already be low, so the host may raise chip select in that cycle.
REQ-020 A start asserted while busy=1 SHALL be ignored and SHALL NOT be queued; changes on data_in during a transfer SHALL NOT affect it.
REQ-021 A start held high continuously SHALL begin a new transfer on the first edge after returning to IDLE, i.e. one idle cycle with busy=0 separates transfers.
REQ-022 The phase counter SHALL be wide enough for HALF_PERIOD, and the bit counter SHALL be wide enough for DATA_WIDTH-1.

Reset
REQ-023 When rst_n=0, the block SHALL immediately force SCLK=0, DIN=0 and busy=0, clear the shift register, bit_count and phase counter, and enter IDLE, even mid-transfer.
REQ-024 After rst_n is deasserted, the block SHALL accept start on the next rising edge of clk.

Verification
REQ-025 Defaults, start pulse of 1 cycle, data_in=16'h0C01 -> busy high for 32 cycles; 16 SCLK rising edges; DIN sampled at those edges = 0000110000000001; SCLK=0 and DIN=0 when busy falls.
REQ-026 data_in=16'hFFFF then 16'h0000 back-to-back, with the host waiting for !busy -> each word is received correctly; busy is low for at least one cycle between the transfers.
REQ-027 Start re-pulsed at cycle 10 of a transfer, with data_in changed to 16'hAAAA -> the current word is sent unchanged; no second transfer occurs.
REQ-028 rst_n pulsed low at cycle 15 of a transfer -> SCLK=0, DIN=0 and busy=0 immediately; a fresh start then sends the full 16 bits.
REQ-029 HALF_PERIOD=3, data_in=16'h0F00 -> every SCLK phase lasts 3 cycles; busy is high for 96 cycles; the bits received are correct.
REQ-030 DATA_WIDTH=8, data_in=8'hA5 -> 8 SCLK rising edges; DIN received = 10100101; busy is high for 16 cycles.
